// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch path.
//   NOP_WORD          : word issued for bubbles and faulted fetches
//   DEFAULT_BASE_ADDR : PC that maps to local index 0 unless overridden
//   fetch_state_t     : instruction-memory FSM states (CLEAR sweep, READY)
//   pc_to_index()     : PC -> local index translation with range/alignment fault
package mips_pkg;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1030;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] index;
    logic        fault;
  } xlate_t;

  // The offset wraps at pc_width, so a PC below base becomes a huge offset and
  // faults. The range test runs on the full offset, never on a truncated index,
  // which is what stops out-of-range PCs from aliasing onto low entries.
  function automatic xlate_t pc_to_index(input logic [63:0] pc,
                                         input logic [63:0] base,
                                         input int unsigned pc_width,
                                         input int unsigned addr_width,
                                         input logic        byte_addr);
    logic [63:0] mask;
    logic [63:0] off;
    logic [63:0] idx;
    xlate_t      r;
    mask    = (pc_width >= 64) ? '1 : ((64'd1 << pc_width) - 64'd1);
    off     = (pc - base) & mask;
    idx     = byte_addr ? (off >> 2) : off;
    r.index = idx;
    r.fault = (idx >= (64'd1 << addr_width)) || (byte_addr && (pc[1:0] != 2'b00));
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch/load bus of the instruction memory.
//   master : pipeline side (drives fetch, stall, flush and load requests)
//   slave  : memory side (returns ready, data_out, data_valid, addr_fault)
//
// Handshake: a fetch is a single-cycle request. It is taken on a rising edge
// when fetch_en=1, stall=0, flush=0 and ready=1; its result appears on
// data_out/data_valid/addr_fault one edge later and stays there until the next
// edge that is not stalled. A load is taken on any edge with load_en=1 and
// ready=1, independent of stall and flush. There is no other backpressure.
interface instr_fetch_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int PC_WIDTH   = 32
);
  logic                  fetch_en;
  logic [PC_WIDTH-1:0]   fetch_addr;
  logic                  stall;
  logic                  flush;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  addr_fault;

  modport master (
    output fetch_en, fetch_addr, stall, flush, load_en, load_addr, load_data,
    input  ready, data_out, data_valid, addr_fault
  );

  modport slave (
    input  fetch_en, fetch_addr, stall, flush, load_en, load_addr, load_data,
    output ready, data_out, data_valid, addr_fault
  );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: synchronous single write port, combinational read port.
// A write and a read of the same index in one cycle return the data being
// written (write-first bypass), so the registered fetch sees the new word.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (bypassed when waddr==raddr and we=1)
module imem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];
endmodule

// File: rtl/instr_fetch_mem.sv
// Parametrised MIPS instruction memory with PC translation, stall/flush,
// runtime program load and an optional post-reset zeroing sweep.
//   clk       : clock (rising edge)
//   rst       : asynchronous active-low reset
//   bus       : fetch/load bus (slave side)
//   state_dbg : current FSM state
module instr_fetch_mem
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0]   BASE_ADDR      = PC_WIDTH'(DEFAULT_BASE_ADDR),
  parameter bit                    BYTE_ADDR      = 1'b0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = DATA_WIDTH'(mips_pkg::NOP_WORD)
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_mem_if.slave    bus,
  output fetch_state_t        state_dbg
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam fetch_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  xlate_t                xl;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  unused_idx_hi;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  fault_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // The sweep owns the write port while in CLEAR; loads only reach the array
  // once READY.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    we          = 1'b0;
    waddr       = bus.load_addr;
    wdata       = bus.load_data;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = NOP_WORD;
        if (clr_cnt == LAST_IDX) state_nxt   = READY;
        else                     clr_cnt_nxt = clr_cnt + 1'b1;
      end
      READY: we = bus.load_en;
      default: state_nxt = RESET_STATE;
    endcase
  end

  assign state_dbg = state;
  assign bus.ready = (state == READY);

  // ---------------- address translation ----------------
  assign xl        = pc_to_index(64'(bus.fetch_addr), 64'(BASE_ADDR),
                                 PC_WIDTH, ADDR_WIDTH, BYTE_ADDR);
  assign fetch_idx = xl.index[ADDR_WIDTH-1:0];
  // Upper index bits are already folded into xl.fault.
  assign unused_idx_hi = ^xl.index[63:ADDR_WIDTH];

  imem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(fetch_idx),
    .rdata(rdata)
  );

  // ---------------- output register ----------------
  // Priority: not ready > flush > stall > fetch > idle bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (state != READY) begin
      data_q  <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.flush) begin
      data_q  <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.fetch_en && !xl.fault) begin
        data_q  <= rdata;
        valid_q <= 1'b1;
        fault_q <= 1'b0;
      end else begin
        data_q  <= NOP_WORD;
        valid_q <= 1'b0;
        fault_q <= bus.fetch_en;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.addr_fault = fault_q;
endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
- Parametrised instruction memory for the MIPS pipeline; successor to the fixed 1K x 32 ROM-style instruction memory.
- Translates a byte- or word-granular PC into a local index using a BASE_ADDR offset, and flags out-of-range fetches.
- Supports stall, flush/bubble injection and a runtime program-load write port.
- Optional post-reset clear sweep: an FSM zeroes the array before fetch is enabled.

Parameters:
- DATA_WIDTH, 32: instruction width in bits.
- ADDR_WIDTH, 10: index width; depth = 2**ADDR_WIDTH.
- PC_WIDTH, 32: width of the fetch address.
- BASE_ADDR, 32'h1030: PC value that maps to index 0.
- BYTE_ADDR, 0: 0 = PC counts words; 1 = PC counts bytes, so index = (PC-BASE_ADDR)>>2.
- CLEAR_ON_RESET, 1: 1 = run the zeroing sweep after reset; 0 = contents are untouched and the block is ready immediately.
- NOP_WORD, 0: word driven for bubbles and faults.

Ports:
- clk  in  1  clock (rising edge).
- rst  in  1  reset; asynchronous, active-low.
- fetch_en  in  1  fetch request this cycle.
- fetch_addr  in  PC_WIDTH  PC to fetch.
- stall  in  1  hold outputs; ignore fetch_en.
- flush  in  1  replace the next output with a bubble.
- load_en  in  1  write request.
- load_addr  in  ADDR_WIDTH  write index (local, not PC).
- load_data  in  DATA_WIDTH  write data.
- ready  out  1  block can accept fetches.
- data_out  out  DATA_WIDTH  fetched instruction (registered).
- data_valid  out  1  data_out holds a real instruction.
- addr_fault  out  1  the fetch was outside [BASE_ADDR, BASE_ADDR+depth) or misaligned (BYTE_ADDR=1, PC[1:0]!=0).

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=NOP_WORD, data_valid=0, addr_fault=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - ready=0 while in CLEAR.
  - Array contents are not reset; they are zeroed only by the sweep.
- FSM states:
  - CLEAR: clear counter runs 0..depth-1, writing NOP_WORD one entry per cycle. After writing depth-1, go to READY on the next edge. ready=1 is first seen exactly depth cycles after rst deasserts.
  - READY: normal operation; stays here until the next reset.
- Reset mid-sweep: asynchronous return to CLEAR with the counter at 0; the sweep restarts from the beginning.
- In CLEAR: fetch_en and load_en are ignored; outputs hold their reset values.
- Fetch latency is 1 cycle. On the edge where fetch_en=1, stall=0, flush=0 and ready=1:
  - Offset computation: off = fetch_addr - BASE_ADDR, computed at PC_WIDTH with unsigned wrap. For BYTE_ADDR=1 this is a byte offset; index = off>>2.
  - Range check: in range iff index < depth, evaluated at full width, never truncated. Any PC below BASE_ADDR wraps to a large value and therefore faults.
  - In range: data_out=mem[index], data_valid=1, addr_fault=0.
  - Out of range or misaligned: data_out=NOP_WORD, data_valid=0, addr_fault=1.
- fetch_en=0 (not stalled): data_out=NOP_WORD, data_valid=0, addr_fault=0.
- stall=1: data_out, data_valid and addr_fault hold their values; fetch_en is ignored.
- flush=1: data_out=NOP_WORD, data_valid=0, addr_fault=0. flush has priority over stall and fetch_en.
- Load port:
  - Accepted only in READY.
  - mem[load_addr] <= load_data at the edge.
  - Writes proceed regardless of stall or flush.
- Same-cycle fetch and load to the same index: the fetch returns the new load_data (write-first bypass).
- Index wrap: there is none. Out-of-range indices fault; they never alias.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_WORD;
  - the default BASE_ADDR (group offset 32'h1030);
  - the FSM state typedef {CLEAR, READY};
  - the address-translation function pc_to_index, which returns the index and a fault bit.
- One sub-module is natural: imem_array, a single-port-write / single-port-read synchronous RAM with write-first bypass.
- The FSM, address translation and output register stay in the top module.

Test Plan:
1. Reset and clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4, release rst, hold fetch_en=1. Required: ready rises after exactly 16 cycles, data_valid stays 0 throughout, and a fetch of 0x1035 then returns 0x00000000.
2. Load then fetch: load mem[0]=0x21E01030 and mem[1]=0x21E11031, then fetch 0x1030 and 0x1031 back-to-back. Required: data_out is 0x21E01030 then 0x21E11031, each one cycle after its request, with data_valid=1.
3. Range and fault: fetch 0x102F, then 0x1030+depth, then (BYTE_ADDR=1) 0x1032. Required: each gives addr_fault=1, data_valid=0, data_out=0.
4. Stall and flush: during a stream of fetches, assert stall for 2 cycles. Required: the output holds. Then assert flush together with stall. Required: the output becomes a bubble (0, data_valid=0).
5. Bypass: fetch 0x1035 and load index 5 = 0xDEADBEEF in the same cycle. Required: data_out=0xDEADBEEF.
6. Reset mid-sweep: pull rst low at sweep cycle 7. Required: outputs go to their reset values immediately, and ready rises depth cycles after rst is released.
